pll_loop_filter: RTL and testbench

Decimating proportional-integral loop filter for the PLL. It sits directly downstream of the FIR phase-error filter: it averages the filtered phase error over `DEC_N` samples and runs a PI update with one shared multiplier. The result is a saturated 32-bit frequency control word for the NCO, with a one-cycle valid strobe. A sequential 4-state datapath keeps DSP usage to one multiplier.

---
 rtl/pll_loop_filter.sv | 191 +++++++++++++++++++
 tb/tb_pll_loop_filter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_loop_filter.sv
// pll_loop_filter
//   Decimating PI loop filter between the FIR phase-error filter and the NCO.
//   Averages DEC_N phase-error samples, then runs a PI update through a short
//   sequential datapath that shares one 16x16 multiplier between the P and I
//   gain products. Produces a saturated unsigned 32-bit frequency word.
//
// Optional feature macro: PLL_LF_HOLD_EN
//   Defined   : adds input 'hold'; while high the integrator is frozen and the
//               proportional term is dropped from the output word.
//   Undefined : no 'hold' port, full PI law on every update.
//
// Ports
//   clk         in   clock, rising edge
//   rst         in   asynchronous reset, active high
//   hold        in   freeze integrator / drop P term (PLL_LF_HOLD_EN only)
//   din[15:0]   in   signed phase error
//   din_valid   in   din accepted on a rising edge while high
//   kp[15:0]    in   signed proportional gain
//   ki[15:0]    in   signed integral gain
//   fcw_center  in   unsigned nominal frequency word
//   fcw_out     out  unsigned frequency control word
//   fcw_valid   out  one-cycle pulse when fcw_out updates
//   int_sat     out  integrator sits at a rail
//   overrun     out  sticky, a block completed while the datapath was busy
//
// FSM states
//   state   | meaning
//   S_IDLE  | waiting for a completed decimation block
//   S_MUL_P | multiplier computes err*kp, registers p_term
//   S_MUL_I | multiplier computes err*ki, registers i_term
//   S_INTEG | saturating integrator update, int_sat refreshed
//   S_OUT   | fcw_center + p_term + integ clamped into fcw_out, fcw_valid pulsed
`timescale 1ns/1ps

module pll_loop_filter #(
  parameter int DEC_N      = 16,
  parameter int GAIN_SHIFT = 8,
  parameter int INT_W      = 32   // assumed >= 32 so the 34-bit terms fit
) (
  input  logic        clk,
  input  logic        rst,
`ifdef PLL_LF_HOLD_EN
  input  logic        hold,
`endif
  input  logic [15:0] din,
  input  logic        din_valid,
  input  logic [15:0] kp,
  input  logic [15:0] ki,
  input  logic [31:0] fcw_center,
  output logic [31:0] fcw_out,
  output logic        fcw_valid,
  output logic        int_sat,
  output logic        overrun
);

  localparam int LOG2  = $clog2(DEC_N);
  localparam int ACC_W = 16 + LOG2;
  localparam int SUM_W = INT_W + 2;
  localparam int OUT_W = INT_W + 3;

  localparam logic signed [INT_W-1:0] INT_MAX = {1'b0, {(INT_W-1){1'b1}}};
  localparam logic signed [INT_W-1:0] INT_MIN = {1'b1, {(INT_W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL_P,
    S_MUL_I,
    S_INTEG,
    S_OUT
  } state_t;

  state_t                   state;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  acc_next;
  logic        [LOG2-1:0]   cnt;
  logic signed [15:0]       err;
  logic signed [33:0]       p_term;
  logic signed [33:0]       i_term;
  logic signed [INT_W-1:0]  integ;
  logic                     start;
  logic                     hold_q;

  logic signed [15:0]       mul_b;
  logic signed [31:0]       prod;
  logic signed [31:0]       prod_sh;
  logic signed [SUM_W-1:0]  isum;
  logic signed [33:0]       p_eff;
  logic signed [OUT_W-1:0]  total;
  logic        [31:0]       fcw_clamped;

`ifdef PLL_LF_HOLD_EN
  assign hold_q = hold;
`else
  assign hold_q = 1'b0;
`endif

  assign acc_next = acc + ACC_W'($signed(din));
  assign start    = din_valid && (cnt == LOG2'(DEC_N - 1));

  // The single multiplier: the second operand follows the state so kp and ki
  // are sampled in the cycle that uses them.
  assign mul_b   = (state == S_MUL_P) ? $signed(kp) : $signed(ki);
  assign prod    = err * mul_b;
  assign prod_sh = prod >>> GAIN_SHIFT;

  assign isum  = SUM_W'(integ) + SUM_W'(i_term);
  assign p_eff = hold_q ? 34'sd0 : p_term;
  assign total = $signed({{(OUT_W-32){1'b0}}, fcw_center}) + OUT_W'(p_eff) + OUT_W'(integ);

  always_comb begin
    fcw_clamped = total[31:0];
    if (total[OUT_W-1])
      fcw_clamped = '0;
    else if (|total[OUT_W-2:32])
      fcw_clamped = '1;
  end

  // Decimator: never stalls. A block that completes while the datapath is
  // busy is dropped (err is left alone so the running update is not
  // corrupted) and flagged through overrun by the FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      cnt <= '0;
      err <= '0;
    end else if (din_valid) begin
      if (start) begin
        if (state == S_IDLE)
          err <= 16'(acc_next >>> LOG2);
        acc <= '0;
        cnt <= '0;
      end else begin
        acc <= acc_next;
        cnt <= cnt + LOG2'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      p_term    <= '0;
      i_term    <= '0;
      integ     <= '0;
      int_sat   <= 1'b0;
      fcw_out   <= '0;
      fcw_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      fcw_valid <= 1'b0;
      if (start && (state != S_IDLE))
        overrun <= 1'b1;
      case (state)
        S_IDLE: begin
          if (start)
            state <= S_MUL_P;
        end
        S_MUL_P: begin
          p_term <= 34'(prod_sh);
          state  <= S_MUL_I;
        end
        S_MUL_I: begin
          i_term <= 34'(prod_sh);
          state  <= S_INTEG;
        end
        S_INTEG: begin
          if (!hold_q) begin
            if (isum > SUM_W'(INT_MAX)) begin
              integ   <= INT_MAX;
              int_sat <= 1'b1;
            end else if (isum < SUM_W'(INT_MIN)) begin
              integ   <= INT_MIN;
              int_sat <= 1'b1;
            end else begin
              integ   <= INT_W'(isum);
              int_sat <= (isum == SUM_W'(INT_MAX)) || (isum == SUM_W'(INT_MIN));
            end
          end
          state <= S_OUT;
        end
        S_OUT: begin
          fcw_out   <= fcw_clamped;
          fcw_valid <= 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pll_loop_filter.sv
`timescale 1ns/1ps

module tb_pll_loop_filter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hold = 1'b0;
  logic [15:0] din = '0;
  logic        din_valid = 1'b0;
  logic [15:0] kp = '0;
  logic [15:0] ki = '0;
  logic [31:0] fcw_center = '0;
  logic [31:0] fcw_out;
  logic        fcw_valid;
  logic        int_sat;
  logic        overrun;

  always #5 clk = ~clk;

  pll_loop_filter dut (
    .clk        (clk),
    .rst        (rst),
`ifdef PLL_LF_HOLD_EN
    .hold       (hold),
`endif
    .din        (din),
    .din_valid  (din_valid),
    .kp         (kp),
    .ki         (ki),
    .fcw_center (fcw_center),
    .fcw_out    (fcw_out),
    .fcw_valid  (fcw_valid),
    .int_sat    (int_sat),
    .overrun    (overrun)
  );

  int n_total = 0;
  int n_pass  = 0;
  bit checking = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic longint floor_div(input longint a, input longint b);
    longint q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  function automatic longint clamp(input longint v, input longint lo, input longint hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  // Behavioural model: block averages and PI law in plain integer arithmetic,
  // results delivered on the documented schedule (int_sat 3 edges, word 4
  // edges after the last sample). Gains are only changed between updates.
  localparam longint I_MAX = 64'sd2147483647;
  localparam longint I_MIN = -64'sd2147483648;
  localparam longint W_MAX = 64'sd4294967295;

  longint m_sum = 0, m_integ = 0, m_out = 0, p_out = 0;
  int     m_cnt = 0, dc = 0;
  bit     m_valid = 1'b0, m_sat = 1'b0, p_sat = 1'b0;

  always @(posedge clk or posedge rst) begin
    longint avg, pp, ii, pe;
    if (rst) begin
      m_sum = 0; m_integ = 0; m_out = 0; p_out = 0;
      m_cnt = 0; dc = 0; m_valid = 0; m_sat = 0; p_sat = 0;
    end else begin
      m_valid = 1'b0;
      if (dc > 0) begin
        dc--;
        if (dc == 1) m_sat = p_sat;
        if (dc == 0) begin
          m_out = p_out;
          m_valid = 1'b1;
        end
      end
      if (din_valid) begin
        m_sum += longint'($signed(din));
        m_cnt++;
        if (m_cnt == 16) begin
          avg = floor_div(m_sum, 16);
          pp  = floor_div(avg * longint'($signed(kp)), 256);
          ii  = floor_div(avg * longint'($signed(ki)), 256);
          if (!hold) m_integ = clamp(m_integ + ii, I_MIN, I_MAX);
          p_sat = (m_integ == I_MAX) || (m_integ == I_MIN);
          pe = hold ? 0 : pp;
          p_out = clamp(longint'(fcw_center) + pe + m_integ, 0, W_MAX);
          dc = 4;
          m_sum = 0;
          m_cnt = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      chk("fcw_valid", fcw_valid, m_valid);
      chk("fcw_out", fcw_out, m_out);
      chk("int_sat", int_sat, m_sat);
      chk("overrun", overrun, 0);
    end
  end

  task automatic step(input logic v, input logic signed [15:0] d);
    din_valid = v;
    din = d;
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input int n, input logic signed [15:0] d);
    for (int i = 0; i < n; i++) step(1'b1, d);
  endtask

  // Feed n samples, then wait (bounded) for the word; lat = -1 if none came.
  task automatic block(input int n, input logic signed [15:0] d,
                       output logic [31:0] val, output int lat);
    feed(n, d);
    lat = -1;
    val = '0;
    for (int k = 1; k <= 10; k++) begin
      step(1'b0, d);
      if (fcw_valid && lat < 0) begin
        lat = k;
        val = fcw_out;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] val;
    int lat;
    int nv;
    int vcyc[$];

    @(posedge clk);
    #1;
    checking = 1'b1;
    chk("rst_fcw_out", fcw_out, 0);
    chk("rst_fcw_valid", fcw_valid, 0);
    chk("rst_int_sat", int_sat, 0);
    chk("rst_overrun", overrun, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // P-only
    kp = 16'd256; ki = 16'd0; fcw_center = 32'h1000_0000;
    for (int b = 0; b < 3; b++) begin
      block(16, 16'sd100, val, lat);
      chk("p_only_lat", lat, 4);
      chk("p_only_val", val, 32'h1000_0064);
    end
    chk("model_p_only", m_out, 32'h1000_0064);

    // Integral
    kp = 16'd0; ki = 16'd256;
    for (int b = 0; b < 3; b++) begin
      block(16, 16'sd1000, val, lat);
      chk("integ_lat", lat, 4);
      chk("integ_val", val, 64'h1000_0000 + 1000 * (b + 1));
      chk("integ_sat", int_sat, 0);
    end
    chk("model_integ", m_out, 32'h1000_0BB8);

    // Reset while the datapath sits in INTEG
    feed(16, 16'sd1000);
    step(1'b0, 16'sd1000);
    step(1'b0, 16'sd1000);
    #1 rst = 1'b1;
    #1;
    chk("midrst_fcw_out", fcw_out, 0);
    chk("midrst_fcw_valid", fcw_valid, 0);
    chk("midrst_int_sat", int_sat, 0);
    chk("midrst_overrun", overrun, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    feed(15, 16'sd1000);
    nv = 0;
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 16'sd1000);
      if (fcw_valid) nv++;
    end
    chk("postrst_no_early_valid", nv, 0);
    block(1, 16'sd1000, val, lat);
    chk("postrst_lat", lat, 4);
    chk("postrst_val", val, 32'h1000_03E8);

    // Gapped input: one sample every third cycle
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    kp = 16'd256; ki = 16'd0; fcw_center = 32'h1000_0000;
    for (int c = 0; c < 160; c++) begin
      step((c < 144) && (c % 3 == 0), 16'sd100);
      if (fcw_valid) begin
        vcyc.push_back(c);
        chk("gap_val", fcw_out, 32'h1000_0064);
      end
    end
    chk("gap_count", vcyc.size(), 3);
    if (vcyc.size() == 3) begin
      chk("gap_first", vcyc[0], 49);
      chk("gap_interval1", vcyc[1] - vcyc[0], 48);
      chk("gap_interval2", vcyc[2] - vcyc[1], 48);
    end

    // Saturation, upper rail then lower rail
    kp = 16'd0; ki = 16'd32767; fcw_center = 32'hF000_0000;
    feed(530 * 16, 16'sd32767);
    repeat (8) step(1'b0, 16'sd0);
    chk("sat_hi_out", fcw_out, 32'hFFFF_FFFF);
    chk("sat_hi_int_sat", int_sat, 1);
    fcw_center = 32'h0;
    feed(1100 * 16, -16'sd32768);
    repeat (8) step(1'b0, 16'sd0);
    chk("sat_lo_out", fcw_out, 0);
    chk("sat_lo_int_sat", int_sat, 1);

`ifdef PLL_LF_HOLD_EN
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    kp = 16'd0; ki = 16'd256; fcw_center = 32'h1000_0000;
    for (int b = 0; b < 3; b++) block(16, 16'sd1000, val, lat);
    chk("hold_pre_val", val, 32'h1000_0BB8);
    hold = 1'b1; kp = 16'd256;
    for (int b = 0; b < 2; b++) begin
      block(16, 16'sd1000, val, lat);
      chk("hold_lat", lat, 4);
      chk("hold_val", val, 32'h1000_0BB8);
    end
    hold = 1'b0;
`endif

    checking = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
